sram_write_arbiter: RTL and testbench
=====================================

# sram_write_arbiter

Round-robin arbiter that shares the SRAM controller's single program-write port (program_x/program_y/program_data) among NUM_REQ pixel producers (player, zombie, bullet and HUD renderers). It sits between the renderers and the SRAM controller and grants at most one pixel per write slot. It holds the winning pixel stable on the controller inputs and counts the pixels committed per frame. Idle slots repeat the previous write, so the controller's unconditional write stages stay harmless.

## Interface
- NUM_REQ, 4, number of requesters (≥2); GW = $clog2(NUM_REQ)
- TRANSPARENT_COLOR, 16'hF81F, colour key for dropped pixels (used only with the macro)
- sram_clk  in  1  100 MHz clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  frame toggle clock, same as fed to the SRAM controller
- write_slot  in  1  one-cycle strobe, one per controller program-write stage (two per 4-cycle round)
- req_valid  in  NUM_REQ  requester i has a pixel pending
- req_ready  out  NUM_REQ  requester i's pixel is consumed this cycle
- req_x  in  10*NUM_REQ  requester i at [i*10 +: 10]
- req_y  in  10*NUM_REQ  requester i at [i*10 +: 10]
- req_data  in  16*NUM_REQ  requester i at [i*16 +: 16]
- program_x, program_y  out  10  to SRAM controller
- program_data  out  16  to SRAM controller
- grant_id  out  GW  index of the last granted requester
- frame_start  out  1  one-cycle pulse per frame_clk rising edge
- last_frame_writes  out  20  committed pixel count of the previous frame

## Operation
- Transfer on requester i = req_valid[i] & req_ready[i] in the same cycle. The requester holds its valid, x, y and data stable until the transfer.
- Arbitration runs only in cycles with write_slot=1. The winner is the first valid requester scanning from rr_ptr upward, with modulo-NUM_REQ wrap.
- req_ready is combinational: req_ready[winner]=1 only when write_slot=1. All other bits are 0, and all bits are 0 while reset_n=0.
- On a transfer, the next edge loads program_* with the winner's x/y/data, loads grant_id with the winner and sets rr_ptr to winner+1, wrapping NUM_REQ-1 to 0.
- A write_slot with no valid requester changes nothing. program_*, grant_id and rr_ptr hold, so the controller rewrites the same pixel with the same value.
- Every write_slot is honoured independently, including strobes on consecutive cycles.
- Frame edge: frame_clk is registered twice (f1, f2). frame_start is registered from f1 & ~f2.
- In the frame_start cycle, last_frame_writes loads write_count, including any transfer in that same cycle. write_count then restarts at 0.
- write_count increments once per non-transparent transfer and saturates at 20'hFFFFF.

## Timing
- Reset values: program_x=0, program_y=0, program_data=16'h0000, grant_id=0, rr_ptr=0, frame_start=0, write_count=0, last_frame_writes=0, f1=f2=0.
- Grant latency: program_* update on the edge ending the write_slot cycle, then stay stable until the next transfer.
- Integration: the top level asserts write_slot exactly one cycle before the edge at which the controller latches the program address.
- frame_start appears 2 cycles after frame_clk rises. It never pulses on a falling edge or while frame_clk is held high.
- Reset mid-operation: pending requests receive no ready and all state returns to reset values. Requesters must re-present their pixels after reset.
- Simultaneous events: a transfer and frame_start in the same cycle both take effect, and that transfer is counted in last_frame_writes.

## Configuration
- SRAM_ARB_TRANSPARENCY_EN defined:
  - A valid request whose data equals TRANSPARENT_COLOR gets req_ready=1 in any cycle, independent of write_slot and of other requesters.
  - That request is excluded from arbitration, never touches program_*, grant_id or rr_ptr, and is not counted.
  - Several transparent pixels may be consumed in one cycle.
- SRAM_ARB_TRANSPARENCY_EN undefined: TRANSPARENT_COLOR is ignored. All pixels arbitrate and are written normally.

## Test plan
- Reset → all outputs at reset values. Requester 2 valid (x=5, y=7, data=16'h1234) with write_slot pulse → req_ready=4'b0100 in that cycle; next cycle program_x=5, program_y=7, program_data=16'h1234, grant_id=2.
- All 4 requesters continuously valid, write_slot every 2 cycles → grants in order 0,1,2,3,0 with exactly one ready per slot.
- No valid requests across 10 slots after a grant of (3, 4, 16'hABCD) → program_* stay (3, 4, 16'hABCD); grant_id and rr_ptr unchanged.
- 100 transfers, then a frame_clk rise with a transfer in the frame_start cycle → last_frame_writes=101 and the counter restarts. A second frame with no transfers → last_frame_writes=0.
- With SRAM_ARB_TRANSPARENCY_EN: requester 1 data=16'hF81F with write_slot=0 → ready[1]=1 immediately; program_* and last_frame_writes unaffected. Without the macro, the same pixel waits for a slot and is written.
- reset_n pulled low while requester 0 is valid mid-stream → req_ready=0 immediately; after release, program_*=0 and the first grant goes to requester 0.

Source files
------------

// File: rtl/sram_write_arbiter.sv
// Round-robin arbiter sharing the SRAM controller program-write port among NUM_REQ pixel producers.
// Optional macro SRAM_ARB_TRANSPARENCY_EN: transparent-colour pixels are consumed immediately and never written.
module sram_write_arbiter #(
  parameter int          NUM_REQ           = 4,
  parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F,
  localparam int         GW                = $clog2(NUM_REQ)
) (
  input  logic                  sram_clk,
  input  logic                  reset_n,
  input  logic                  frame_clk,
  input  logic                  write_slot,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [10*NUM_REQ-1:0] req_x,
  input  logic [10*NUM_REQ-1:0] req_y,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [9:0]            program_x,
  output logic [9:0]            program_y,
  output logic [15:0]           program_data,
  output logic [GW-1:0]         grant_id,
  output logic                  frame_start,
  output logic [19:0]           last_frame_writes
);

`ifdef SRAM_ARB_TRANSPARENCY_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (v == 20'hFFFFF) ? v : v + 20'd1;
  endfunction

  logic [9:0]         program_x_q, program_x_d;
  logic [9:0]         program_y_q, program_y_d;
  logic [15:0]        program_data_q, program_data_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [GW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               f1_q, f1_d, f2_q, f2_d;
  logic               frame_start_q, frame_start_d;
  logic [19:0]        write_count_q, write_count_d;
  logic [19:0]        last_frame_writes_q, last_frame_writes_d;

  logic [NUM_REQ-1:0] transp, eligible, grant_oh;
  logic [GW-1:0]      idx, winner;
  logic               found, xfer;
  logic [9:0]         sel_x, sel_y;
  logic [15:0]        sel_data;
  logic [19:0]        cnt_inc;

  always_comb begin
    transp   = '0;
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      transp[i]   = TRANSP_EN && req_valid[i] && (req_data[i*16 +: 16] == TRANSPARENT_COLOR);
      eligible[i] = req_valid[i] && !transp[i];
    end
  end

  // First eligible requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    sel_x    = '0;
    sel_y    = '0;
    sel_data = '0;
    grant_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) begin
        sel_x    = req_x[i*10 +: 10];
        sel_y    = req_y[i*10 +: 10];
        sel_data = req_data[i*16 +: 16];
        grant_oh[i] = write_slot && found;
      end
    end
  end

  assign xfer      = write_slot && found;
  assign req_ready = reset_n ? (grant_oh | transp) : '0;

  always_comb begin
    program_x_d         = program_x_q;
    program_y_d         = program_y_q;
    program_data_d      = program_data_q;
    grant_id_d          = grant_id_q;
    rr_ptr_d            = rr_ptr_q;
    f1_d                = frame_clk;
    f2_d                = f1_q;
    frame_start_d       = f1_q && !f2_q;
    last_frame_writes_d = last_frame_writes_q;
    if (xfer) begin
      program_x_d    = sel_x;
      program_y_d    = sel_y;
      program_data_d = sel_data;
      grant_id_d     = winner;
      rr_ptr_d       = (winner == GW'(NUM_REQ-1)) ? '0 : winner + GW'(1);
    end
    cnt_inc = xfer ? sat_inc(write_count_q) : write_count_q;
    // A transfer landing in the frame_start cycle belongs to the frame just closed.
    if (frame_start_q) begin
      last_frame_writes_d = cnt_inc;
      write_count_d       = '0;
    end else begin
      write_count_d = cnt_inc;
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      program_x_q         <= '0;
      program_y_q         <= '0;
      program_data_q      <= '0;
      grant_id_q          <= '0;
      rr_ptr_q            <= '0;
      f1_q                <= 1'b0;
      f2_q                <= 1'b0;
      frame_start_q       <= 1'b0;
      write_count_q       <= '0;
      last_frame_writes_q <= '0;
    end else begin
      program_x_q         <= program_x_d;
      program_y_q         <= program_y_d;
      program_data_q      <= program_data_d;
      grant_id_q          <= grant_id_d;
      rr_ptr_q            <= rr_ptr_d;
      f1_q                <= f1_d;
      f2_q                <= f2_d;
      frame_start_q       <= frame_start_d;
      write_count_q       <= write_count_d;
      last_frame_writes_q <= last_frame_writes_d;
    end
  end

  assign program_x         = program_x_q;
  assign program_y         = program_y_q;
  assign program_data      = program_data_q;
  assign grant_id          = grant_id_q;
  assign frame_start       = frame_start_q;
  assign last_frame_writes = last_frame_writes_q;

endmodule

// File: tb/tb_sram_write_arbiter.sv
// Directed bench for sram_write_arbiter: grants, round-robin order, hold, frame counting, transparency, reset.
module tb_sram_write_arbiter;

  logic        sram_clk = 1'b0;
  logic        reset_n;
  logic        frame_clk;
  logic        write_slot;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [39:0] req_x;
  logic [39:0] req_y;
  logic [63:0] req_data;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic [1:0]  grant_id;
  logic        frame_start;
  logic [19:0] last_frame_writes;

  int n_checks = 0;
  int n_errors = 0;

  sram_write_arbiter dut (
    .sram_clk(sram_clk), .reset_n(reset_n), .frame_clk(frame_clk), .write_slot(write_slot),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_data(req_data), .program_x(program_x), .program_y(program_y),
    .program_data(program_data), .grant_id(grant_id), .frame_start(frame_start),
    .last_frame_writes(last_frame_writes)
  );

  always #5 sram_clk = ~sram_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [9:0] x, input logic [9:0] y,
                         input logic [15:0] d);
    req_valid[i]         = v;
    req_x[i*10 +: 10]    = x;
    req_y[i*10 +: 10]    = y;
    req_data[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge sram_clk);
    reset_n = 1'b0;
    @(negedge sram_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; frame_clk = 1'b0; write_slot = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; req_data = '0;
    set_req(0, 1'b1, 10'd1, 10'd1, 16'h0101);
    repeat (2) @(posedge sram_clk);
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_px", program_x, 0);
    chk("rst_py", program_y, 0);
    chk("rst_pd", program_data, 16'h0000);
    chk("rst_gid", grant_id, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_lfw", last_frame_writes, 0);
    @(negedge sram_clk);
    reset_n = 1'b1; req_valid = '0;

    // single grant to requester 2
    @(negedge sram_clk);
    set_req(2, 1'b1, 10'd5, 10'd7, 16'h1234);
    write_slot = 1'b1;
    #1 chk("t1_ready", req_ready, 4'b0100);
    @(posedge sram_clk); #1;
    chk("t1_px", program_x, 5);
    chk("t1_py", program_y, 7);
    chk("t1_pd", program_data, 16'h1234);
    chk("t1_gid", grant_id, 2);
    @(negedge sram_clk);
    req_valid = '0; write_slot = 1'b0;

    // round robin with all requesters valid
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 10'(i), 10'(10 + i), 16'hA000 + 16'(i));
    for (int s = 0; s < 5; s++) begin
      @(negedge sram_clk);
      write_slot = 1'b1;
      #1 chk("rr_ready", req_ready, 4'b0001 << (s % 4));
      @(posedge sram_clk); #1;
      chk("rr_gid", grant_id, s % 4);
      chk("rr_pd", program_data, 16'hA000 + (s % 4));
      @(negedge sram_clk);
      write_slot = 1'b0;
    end

    // hold across idle slots
    req_valid = '0;
    set_req(3, 1'b1, 10'd3, 10'd4, 16'hABCD);
    @(negedge sram_clk);
    write_slot = 1'b1;
    @(posedge sram_clk); #1;
    chk("hold_gid0", grant_id, 3);
    @(negedge sram_clk);
    req_valid = '0; write_slot = 1'b0;
    for (int s = 0; s < 10; s++) begin
      @(negedge sram_clk);
      write_slot = 1'b1;
      #1 chk("idle_ready", req_ready, 4'b0000);
      @(negedge sram_clk);
      write_slot = 1'b0;
    end
    chk("hold_px", program_x, 3);
    chk("hold_py", program_y, 4);
    chk("hold_pd", program_data, 16'hABCD);
    chk("hold_gid", grant_id, 3);
    write_slot = 1'b1; req_valid = 4'b1111;
    #1 chk("hold_rrptr", req_ready, 4'b0001);
    @(posedge sram_clk); #1;
    chk("hold_gid_next", grant_id, 0);
    @(negedge sram_clk);
    write_slot = 1'b0; req_valid = '0;

    // frame counting: 100 transfers plus one in the frame_start cycle
    do_reset();
    set_req(0, 1'b1, 10'd11, 10'd22, 16'h5555);
    @(negedge sram_clk);
    write_slot = 1'b1;
    repeat (100) @(posedge sram_clk);
    @(negedge sram_clk);
    write_slot = 1'b0; frame_clk = 1'b1;
    @(posedge sram_clk); #1;
    chk("fs_early", frame_start, 0);
    @(posedge sram_clk); #1;
    chk("fs_pulse", frame_start, 1);
    chk("lfw_before", last_frame_writes, 0);
    @(negedge sram_clk);
    write_slot = 1'b1;
    @(posedge sram_clk); #1;
    chk("lfw_101", last_frame_writes, 101);
    chk("fs_end", frame_start, 0);
    @(negedge sram_clk);
    write_slot = 1'b0; req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge sram_clk); #1;
      chk("fs_held_high", frame_start, 0);
    end
    @(negedge sram_clk);
    frame_clk = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge sram_clk); #1;
      chk("fs_falling", frame_start, 0);
    end
    chk("lfw_keep", last_frame_writes, 101);
    @(negedge sram_clk);
    frame_clk = 1'b1;
    repeat (2) @(posedge sram_clk);
    #1 chk("fs_pulse2", frame_start, 1);
    @(posedge sram_clk); #1;
    chk("lfw_zero", last_frame_writes, 0);

    // transparent colour pixel
    @(negedge sram_clk);
    set_req(1, 1'b1, 10'd8, 10'd9, 16'hF81F);
    write_slot = 1'b0;
`ifdef SRAM_ARB_TRANSPARENCY_EN
    #1 chk("tr_ready", req_ready, 4'b0010);
    @(posedge sram_clk); #1;
    chk("tr_pd", program_data, 16'h5555);
    chk("tr_px", program_x, 11);
    chk("tr_lfw", last_frame_writes, 0);
    @(negedge sram_clk);
    set_req(3, 1'b1, 10'd1, 10'd2, 16'h0F0F);
    write_slot = 1'b1;
    #1 chk("tr_both", req_ready, 4'b1010);
    @(posedge sram_clk); #1;
    chk("tr_gid", grant_id, 3);
`else
    #1 chk("ntr_wait", req_ready, 4'b0000);
    @(negedge sram_clk);
    write_slot = 1'b1;
    #1 chk("ntr_ready", req_ready, 4'b0010);
    @(posedge sram_clk); #1;
    chk("ntr_pd", program_data, 16'hF81F);
    chk("ntr_gid", grant_id, 1);
`endif
    @(negedge sram_clk);
    write_slot = 1'b0; req_valid = '0;

    // reset mid-operation
    set_req(2, 1'b1, 10'd6, 10'd6, 16'h2222);
    @(negedge sram_clk);
    write_slot = 1'b1;
    @(posedge sram_clk); #1;
    chk("mid_gid2", grant_id, 2);
    @(negedge sram_clk);
    reset_n = 1'b0;
    req_valid = 4'b0101;
    #1 chk("mid_ready", req_ready, 4'b0000);
    @(posedge sram_clk); #1;
    chk("mid_px", program_x, 0);
    chk("mid_pd", program_data, 16'h0000);
    chk("mid_gid", grant_id, 0);
    @(negedge sram_clk);
    reset_n = 1'b1;
    #1 chk("post_ready", req_ready, 4'b0001);
    @(posedge sram_clk); #1;
    chk("post_gid", grant_id, 0);
    chk("post_px", program_x, 11);
    @(negedge sram_clk);
    write_slot = 1'b0; req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
